// File: rtl/wb_arb2_if.sv
// Bus bundle between two Wishbone-style masters, the shared memory slave and the wb_arb2 arbiter.
interface wb_arb2_if;
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;

    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [DW-1:0] m0_dat_o;
    logic          m0_we_i;
    logic          m0_byte_i;
    logic          m0_stb_i;
    logic          m0_ack_o;

    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [DW-1:0] m1_dat_o;
    logic          m1_we_i;
    logic          m1_byte_i;
    logic          m1_stb_i;
    logic          m1_ack_o;

    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic          s_we_o;
    logic          s_byte_o;
    logic          s_stb_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;

    logic          err_o;
    logic [1:0]    grant_o;

    // Arbiter side: sees both masters and the slave response, drives everything else.
    modport slave (
        input  m0_adr_i, m0_dat_i, m0_we_i, m0_byte_i, m0_stb_i,
        output m0_dat_o, m0_ack_o,
        input  m1_adr_i, m1_dat_i, m1_we_i, m1_byte_i, m1_stb_i,
        output m1_dat_o, m1_ack_o,
        output s_adr_o, s_dat_o, s_we_o, s_byte_o, s_stb_o,
        input  s_dat_i, s_ack_i,
        output err_o, grant_o
    );

    // Environment side: the two masters plus the memory slave.
    modport master (
        output m0_adr_i, m0_dat_i, m0_we_i, m0_byte_i, m0_stb_i,
        input  m0_dat_o, m0_ack_o,
        output m1_adr_i, m1_dat_i, m1_we_i, m1_byte_i, m1_stb_i,
        input  m1_dat_o, m1_ack_o,
        input  s_adr_o, s_dat_o, s_we_o, s_byte_o, s_stb_o,
        output s_dat_i, s_ack_i,
        input  err_o, grant_o
    );
endinterface

// File: rtl/wb_arb2.sv
// Two-master round-robin arbiter for a shared memory slave, with a per-access ack timeout.
// The request path is combinational from the granted master; grant changes take one cycle.
module wb_arb2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    wb_arb2_if.slave   bus
);
    localparam int unsigned CW_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW     = (CW_RAW > 8) ? CW_RAW : 8;
    localparam int unsigned AW     = 20;
    localparam int unsigned DW     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Fields of whichever master currently holds the grant.
    logic [AW-1:0] sel_adr;
    logic [DW-1:0] sel_dat;
    logic          sel_we, sel_byte, sel_stb;
    logic [DW-1:0] rsp_dat;
    logic          rsp_ack;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cnt_d        = '0;
        rsp_dat      = '0;
        rsp_ack      = 1'b0;
        bus.s_adr_o  = '0;
        bus.s_dat_o  = '0;
        bus.s_we_o   = 1'b0;
        bus.s_byte_o = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.m0_dat_o = '0;
        bus.m0_ack_o = 1'b0;
        bus.m1_dat_o = '0;
        bus.m1_ack_o = 1'b0;
        bus.err_o    = 1'b0;
        bus.grant_o  = 2'(state_q);

        sel_adr  = (state_q == GNT1) ? bus.m1_adr_i  : bus.m0_adr_i;
        sel_dat  = (state_q == GNT1) ? bus.m1_dat_i  : bus.m0_dat_i;
        sel_we   = (state_q == GNT1) ? bus.m1_we_i   : bus.m0_we_i;
        sel_byte = (state_q == GNT1) ? bus.m1_byte_i : bus.m0_byte_i;
        sel_stb  = (state_q == GNT1) ? bus.m1_stb_i  : bus.m0_stb_i;

        case (state_q)
            IDLE: begin
                // last_q names the master served most recently; the other one wins a tie.
                if (bus.m0_stb_i && bus.m1_stb_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (bus.m0_stb_i) begin
                    state_d = GNT0;
                end else if (bus.m1_stb_i) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                bus.s_adr_o  = sel_adr;
                bus.s_dat_o  = sel_dat;
                bus.s_we_o   = sel_we;
                bus.s_byte_o = sel_byte;
                bus.s_stb_o  = sel_stb;
                rsp_dat      = bus.s_dat_i;
                rsp_ack      = bus.s_ack_i;
                if (bus.s_ack_i) begin
                    state_d = IDLE;
                    last_d  = (state_q == GNT1);
                end else if (!sel_stb) begin
                    // Master withdrew: leave without an ack and without touching fairness.
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    bus.s_stb_o = 1'b0;
                    rsp_ack     = 1'b1;
                    rsp_dat     = {DW{1'b1}};
                    bus.err_o   = 1'b1;
                    state_d     = IDLE;
                    last_d      = (state_q == GNT1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q == GNT0) begin
            bus.m0_dat_o = rsp_dat;
            bus.m0_ack_o = rsp_ack;
        end
        if (state_q == GNT1) begin
            bus.m1_dat_o = rsp_dat;
            bus.m1_ack_o = rsp_ack;
        end
    end
endmodule

// File: tb/tb_wb_arb2.sv
// Directed testbench for wb_arb2 (TIMEOUT=4): reset, read, contention, byte write, timeout, abort, mid-access reset.
module tb_wb_arb2;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    wb_arb2_if bus();

    wb_arb2 #(.TIMEOUT(4)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic clear_inputs();
        bus.m0_adr_i = '0; bus.m0_dat_i = '0; bus.m0_we_i = 1'b0; bus.m0_byte_i = 1'b0; bus.m0_stb_i = 1'b0;
        bus.m1_adr_i = '0; bus.m1_dat_i = '0; bus.m1_we_i = 1'b0; bus.m1_byte_i = 1'b0; bus.m1_stb_i = 1'b0;
        bus.s_dat_i  = '0; bus.s_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        bus.m0_stb_i = 1'b1;
        #3;
        checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL rst_grant got=%b exp=00", bus.grant_o); end
        checks++; if (bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL rst_s_stb got=%b exp=0", bus.s_stb_o); end
        checks++; if (bus.s_adr_o !== 20'h0) begin errors++; $display("FAIL rst_s_adr got=%h exp=0", bus.s_adr_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", bus.err_o); end
        step();
        checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL rst_hold_grant got=%b exp=00", bus.grant_o); end
        checks++; if (bus.m0_ack_o !== 1'b0 || bus.m1_ack_o !== 1'b0) begin errors++; $display("FAIL rst_acks got=%b%b exp=00", bus.m0_ack_o, bus.m1_ack_o); end
        bus.m0_stb_i = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read();
        bus.m0_adr_i = 20'h00B70; bus.m0_we_i = 1'b0; bus.m0_stb_i = 1'b1;
        #1;
        checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL rd_latency got=%b exp=00", bus.grant_o); end
        checks++; if (bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL rd_idle_stb got=%b exp=0", bus.s_stb_o); end
        step();
        checks++; if (bus.grant_o !== 2'b01) begin errors++; $display("FAIL rd_grant got=%b exp=01", bus.grant_o); end
        checks++; if (bus.s_stb_o !== 1'b1) begin errors++; $display("FAIL rd_s_stb got=%b exp=1", bus.s_stb_o); end
        checks++; if (bus.s_adr_o !== 20'h00B70) begin errors++; $display("FAIL rd_s_adr got=%h exp=00b70", bus.s_adr_o); end
        checks++; if (bus.s_we_o !== 1'b0) begin errors++; $display("FAIL rd_s_we got=%b exp=0", bus.s_we_o); end
        step();
        checks++; if (bus.m0_ack_o !== 1'b0) begin errors++; $display("FAIL rd_early_ack got=%b exp=0", bus.m0_ack_o); end
        step();
        bus.s_ack_i = 1'b1; bus.s_dat_i = 16'h1234;
        #1;
        checks++; if (bus.m0_ack_o !== 1'b1) begin errors++; $display("FAIL rd_ack got=%b exp=1", bus.m0_ack_o); end
        checks++; if (bus.m0_dat_o !== 16'h1234) begin errors++; $display("FAIL rd_dat got=%h exp=1234", bus.m0_dat_o); end
        checks++; if (bus.m1_ack_o !== 1'b0 || bus.m1_dat_o !== 16'h0) begin errors++; $display("FAIL rd_m1_quiet got=%b/%h exp=0/0000", bus.m1_ack_o, bus.m1_dat_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", bus.err_o); end
        step();
        bus.m0_stb_i = 1'b0; bus.s_ack_i = 1'b0;
        #1;
        checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL rd_back_idle got=%b exp=00", bus.grant_o); end
        bus.s_ack_i = 1'b1;
        #1;
        checks++; if (bus.m0_ack_o !== 1'b0 || bus.m1_ack_o !== 1'b0) begin errors++; $display("FAIL rd_idle_ack_fwd got=%b%b exp=00", bus.m0_ack_o, bus.m1_ack_o); end
        bus.s_ack_i = 1'b0;
        step();
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g;
        logic        w_ack, o_ack;
        logic [15:0] w_dat, o_dat;
        do_reset();
        bus.s_dat_i = 16'h5A5A;
        bus.m0_stb_i = 1'b1; bus.m1_stb_i = 1'b1;
        #1;
        checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL rr_start got=%b exp=00", bus.grant_o); end
        for (int i = 0; i < 4; i++) begin
            exp_g = i[0] ? 2'b10 : 2'b01;
            step();
            checks++; if (bus.grant_o !== exp_g) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, bus.grant_o, exp_g); end
            bus.s_ack_i = 1'b1;
            #1;
            w_ack = i[0] ? bus.m1_ack_o : bus.m0_ack_o;
            o_ack = i[0] ? bus.m0_ack_o : bus.m1_ack_o;
            w_dat = i[0] ? bus.m1_dat_o : bus.m0_dat_o;
            o_dat = i[0] ? bus.m0_dat_o : bus.m1_dat_o;
            checks++; if (w_ack !== 1'b1 || w_dat !== 16'h5A5A) begin errors++; $display("FAIL rr_winner%0d got=%b/%h exp=1/5a5a", i, w_ack, w_dat); end
            checks++; if (o_ack !== 1'b0 || o_dat !== 16'h0) begin errors++; $display("FAIL rr_loser%0d got=%b/%h exp=0/0000", i, o_ack, o_dat); end
            step();
            bus.s_ack_i = 1'b0;
            #1;
            checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL rr_gap%0d got=%b exp=00", i, bus.grant_o); end
        end
        bus.m0_stb_i = 1'b0; bus.m1_stb_i = 1'b0;
        step();
    endtask

    task automatic test_byte_write();
        bus.m1_adr_i = 20'hF0000; bus.m1_dat_i = 16'h00AB; bus.m1_we_i = 1'b1; bus.m1_byte_i = 1'b1; bus.m1_stb_i = 1'b1;
        step();
        checks++; if (bus.grant_o !== 2'b10) begin errors++; $display("FAIL bw_grant got=%b exp=10", bus.grant_o); end
        checks++; if (bus.s_we_o !== 1'b1 || bus.s_byte_o !== 1'b1) begin errors++; $display("FAIL bw_we_byte got=%b%b exp=11", bus.s_we_o, bus.s_byte_o); end
        checks++; if (bus.s_adr_o !== 20'hF0000) begin errors++; $display("FAIL bw_adr got=%h exp=f0000", bus.s_adr_o); end
        checks++; if (bus.s_dat_o !== 16'h00AB) begin errors++; $display("FAIL bw_dat got=%h exp=00ab", bus.s_dat_o); end
        bus.s_ack_i = 1'b1;
        #1;
        checks++; if (bus.m1_ack_o !== 1'b1) begin errors++; $display("FAIL bw_m1_ack got=%b exp=1", bus.m1_ack_o); end
        checks++; if (bus.m0_ack_o !== 1'b0) begin errors++; $display("FAIL bw_m0_ack got=%b exp=0", bus.m0_ack_o); end
        step();
        bus.s_ack_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_byte_i = 1'b0;
        #1;
        checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL bw_idle got=%b exp=00", bus.grant_o); end
        step();
    endtask

    task automatic test_timeout();
        bus.m0_adr_i = 20'h12345; bus.m0_stb_i = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.err_o !== 1'b0 || bus.m0_ack_o !== 1'b0 || bus.s_stb_o !== 1'b1) begin errors++; $display("FAIL to_wait%0d got=err%b ack%b stb%b exp=err0 ack0 stb1", k, bus.err_o, bus.m0_ack_o, bus.s_stb_o); end
            step();
        end
        #1;
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", bus.err_o); end
        checks++; if (bus.m0_ack_o !== 1'b1 || bus.m0_dat_o !== 16'hFFFF) begin errors++; $display("FAIL to_ack got=%b/%h exp=1/ffff", bus.m0_ack_o, bus.m0_dat_o); end
        checks++; if (bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL to_s_stb got=%b exp=0", bus.s_stb_o); end
        step();
        bus.m0_stb_i = 1'b0;
        #1;
        checks++; if (bus.grant_o !== 2'b00 || bus.err_o !== 1'b0) begin errors++; $display("FAIL to_idle got=%b err%b exp=00 err0", bus.grant_o, bus.err_o); end
        step();
    endtask

    task automatic test_ack_at_timeout();
        bus.m0_stb_i = 1'b1;
        step();
        for (int k = 0; k < 4; k++) step();
        bus.s_ack_i = 1'b1; bus.s_dat_i = 16'h7777;
        #1;
        checks++; if (bus.m0_ack_o !== 1'b1 || bus.m0_dat_o !== 16'h7777) begin errors++; $display("FAIL tie_ack got=%b/%h exp=1/7777", bus.m0_ack_o, bus.m0_dat_o); end
        checks++; if (bus.err_o !== 1'b0 || bus.s_stb_o !== 1'b1) begin errors++; $display("FAIL tie_err_stb got=err%b stb%b exp=err0 stb1", bus.err_o, bus.s_stb_o); end
        step();
        bus.s_ack_i = 1'b0; bus.m0_stb_i = 1'b0;
        #1;
        checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL tie_idle got=%b exp=00", bus.grant_o); end
        step();
    endtask

    task automatic test_abort();
        do_reset();
        bus.m0_stb_i = 1'b1;
        step();
        checks++; if (bus.grant_o !== 2'b01) begin errors++; $display("FAIL ab_grant got=%b exp=01", bus.grant_o); end
        bus.m0_stb_i = 1'b0;
        #1;
        checks++; if (bus.m0_ack_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL ab_drop got=ack%b stb%b exp=ack0 stb0", bus.m0_ack_o, bus.s_stb_o); end
        step();
        checks++; if (bus.grant_o !== 2'b00 || bus.m0_ack_o !== 1'b0) begin errors++; $display("FAIL ab_idle got=%b ack%b exp=00 ack0", bus.grant_o, bus.m0_ack_o); end
        bus.m0_stb_i = 1'b1; bus.m1_stb_i = 1'b1;
        step();
        checks++; if (bus.grant_o !== 2'b01) begin errors++; $display("FAIL ab_last_kept got=%b exp=01", bus.grant_o); end
        bus.s_ack_i = 1'b1;
        step();
        bus.s_ack_i = 1'b0; bus.m0_stb_i = 1'b0;
        step();
        checks++; if (bus.grant_o !== 2'b10) begin errors++; $display("FAIL ab_pending_m1 got=%b exp=10", bus.grant_o); end
        bus.s_ack_i = 1'b1;
        step();
        bus.s_ack_i = 1'b0; bus.m1_stb_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bus.m1_adr_i = 20'h0ABCD; bus.m1_stb_i = 1'b1;
        step();
        checks++; if (bus.grant_o !== 2'b10) begin errors++; $display("FAIL rm_grant got=%b exp=10", bus.grant_o); end
        step();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.grant_o !== 2'b00 || bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL rm_async got=%b stb%b exp=00 stb0", bus.grant_o, bus.s_stb_o); end
        checks++; if (bus.s_adr_o !== 20'h0) begin errors++; $display("FAIL rm_adr got=%h exp=0", bus.s_adr_o); end
        bus.s_ack_i = 1'b1;
        #1;
        checks++; if (bus.m1_ack_o !== 1'b0) begin errors++; $display("FAIL rm_no_ack got=%b exp=0", bus.m1_ack_o); end
        bus.s_ack_i = 1'b0; bus.m0_stb_i = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL rm_release got=%b exp=00", bus.grant_o); end
        step();
        checks++; if (bus.grant_o !== 2'b01) begin errors++; $display("FAIL rm_contend got=%b exp=01", bus.grant_o); end
        bus.s_ack_i = 1'b1;
        step();
        bus.s_ack_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m1_stb_i = 1'b0;
        #1;
        checks++; if (bus.grant_o !== 2'b00) begin errors++; $display("FAIL rm_end got=%b exp=00", bus.grant_o); end
        step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_contention();
        test_byte_write();
        test_timeout();
        test_ack_at_timeout();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
